// File: rtl/df_fir_mac_if.sv
// Handshake and coefficient-write bundle for the df_fir_mac FIR stage.
// The master side is the sample source and result consumer; the slave side is the filter.
interface df_fir_mac_if #(
    parameter int TAPS = 4
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_sample;
    logic [8:0]    offset;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [3:0]    coef_data;
    logic          out_valid;
    logic          out_ready;
    logic [8:0]    out_a;
    logic [8:0]    out_b;
    logic          out_sat;

    modport master (
        output in_valid, in_sample, offset, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_sat
    );

    modport slave (
        input  in_valid, in_sample, offset, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_sat
    );
endinterface

// File: rtl/df_fir_mac.sv
// Serial FIR multiply-accumulate: one tap per clock over a TAPS-deep delay line,
// then arithmetic shift and clamp to a 9-bit signed operand paired with a DC offset.
module df_fir_mac #(
    parameter int TAPS  = 4,
    parameter int SHIFT = 2
) (
    input logic         clk,
    input logic         rst_n,
    df_fir_mac_if.slave bus
);
    localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int ACC_W = 12 + $clog2(TAPS);
    localparam logic [AW-1:0]           LAST_IDX = AW'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] CLAMP_HI = ACC_W'(255);
    localparam logic signed [ACC_W-1:0] CLAMP_LO = ACC_W'(-256);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                   state_r, state_s;
    logic [7:0]               x_r    [TAPS];
    logic signed [3:0]        coef_r [TAPS];
    logic signed [ACC_W-1:0]  acc_r;
    logic [AW-1:0]            idx_r;
    logic [8:0]               off_r;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic [8:0]               out_a_r;
    logic [8:0]               out_b_r;
    logic                     out_sat_r;

    logic                     accept_s;
    logic                     load_s;
    logic                     done_s;
    logic                     coef_wr_s;
    logic signed [ACC_W-1:0]  x_ext_s;
    logic signed [ACC_W-1:0]  c_ext_s;
    logic signed [ACC_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]  shifted_s;
    logic [8:0]               clamp_s;
    logic                     sat_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; OUT loads the result on its first edge, then waits for the handshake.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        load_s   = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    state_s  = ST_MAC;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_MAC;
                end
            end
            ST_OUT: begin
                if (!out_valid_r) begin
                    load_s  = 1'b1;
                end else if (bus.out_ready) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Unsigned sample times signed coefficient, both widened to the accumulator width.
    always_comb begin
        x_ext_s   = {{(ACC_W-8){1'b0}}, x_r[idx_r]};
        c_ext_s   = {{(ACC_W-4){coef_r[idx_r][3]}}, coef_r[idx_r]};
        prod_s    = x_ext_s * c_ext_s;
        coef_wr_s = (state_r == ST_IDLE) && bus.coef_we && (int'(bus.coef_addr) < TAPS);
    end

    // Floor shift first, then clamp into the 9-bit signed operand range.
    always_comb begin
        shifted_s = acc_r >>> SHIFT;
        clamp_s   = shifted_s[8:0];
        sat_s     = 1'b0;
        if (shifted_s > CLAMP_HI) begin
            clamp_s = 9'h0FF;
            sat_s   = 1'b1;
        end else if (shifted_s < CLAMP_LO) begin
            clamp_s = 9'h100;
            sat_s   = 1'b1;
        end else begin
            clamp_s = shifted_s[8:0];
            sat_s   = 1'b0;
        end
    end

    // Delay line, coefficients, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_r[k]    <= 8'd0;
                coef_r[k] <= 4'sd0;
            end
            coef_r[0]   <= 4'sd4;
            acc_r       <= '0;
            idx_r       <= '0;
            off_r       <= 9'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_a_r     <= 9'd0;
            out_b_r     <= 9'd0;
            out_sat_r   <= 1'b0;
        end else begin
            in_ready_r <= (state_s == ST_IDLE);
            if (coef_wr_s) begin
                coef_r[bus.coef_addr] <= bus.coef_data;
            end
            if (accept_s) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    x_r[k] <= x_r[k-1];
                end
                x_r[0] <= bus.in_sample;
                off_r  <= bus.offset;
                acc_r  <= '0;
                idx_r  <= '0;
            end else if (state_r == ST_MAC) begin
                acc_r <= acc_r + prod_s;
                idx_r <= idx_r + 1'b1;
            end
            if (load_s) begin
                out_a_r     <= clamp_s;
                out_b_r     <= off_r;
                out_sat_r   <= sat_s;
                out_valid_r <= 1'b1;
            end else if (done_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_a     = out_a_r;
    assign bus.out_b     = out_b_r;
    assign bus.out_sat   = out_sat_r;
endmodule
